// File: rtl/fp_pkg.sv
// Shared sizing helpers for the front-panel scanner: row-group count, key
// indexing and debounce counter width.
package fp_pkg;

  localparam int unsigned FP_DEB_FRAMES_DEF = 3;
  localparam int unsigned FP_DEB_CNT_W      = $clog2(FP_DEB_FRAMES_DEF + 1);

  function automatic int unsigned fp_ngrp(input int unsigned width,
                                          input int unsigned ncolors,
                                          input int unsigned nled);
    return (width * ncolors) / nled;
  endfunction

  // Return line k during row s maps to key k*NGRP+s.
  function automatic int unsigned fp_key_idx(input int unsigned k,
                                             input int unsigned s,
                                             input int unsigned ngrp);
    return k * ngrp + s;
  endfunction

  function automatic int unsigned fp_cnt_w(input int unsigned deb_frames);
    return $clog2(deb_frames + 1);
  endfunction

endpackage

// File: rtl/fp_key_debounce.sv
// One key of the panel matrix: raw sample, frame-based debounce counter and
// the stable level with its change strobe (valid on the frame-end clock).
module fp_key_debounce
  import fp_pkg::*;
#(
  parameter int unsigned DEB_FRAMES = FP_DEB_FRAMES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  input  logic sense,
  input  logic frame_end,
  output logic stable,
  output logic change
);

  localparam int unsigned CNT_W = fp_cnt_w(DEB_FRAMES);

  logic             raw;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    change = frame_end && (raw != stable) && (cnt == CNT_W'(DEB_FRAMES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw    <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      if (sample)
        raw <= sense;
      if (frame_end) begin
        if (raw == stable) begin
          cnt <= '0;
        end else if (change) begin
          stable <= raw;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/front_panel_scanner.sv
// PDP-8 front panel LED/switch matrix scanner. Optional lamp test input is
// enabled with the FP_LAMP_TEST_EN macro.
module front_panel_scanner
  import fp_pkg::*;
#(
  parameter int unsigned WIDTH      = 12,
  parameter int unsigned NCOLORS    = 3,
  parameter int unsigned NLED       = 6,
  parameter int unsigned NSENSE     = 3,
  parameter int unsigned DWELL_W    = 4,
  parameter int unsigned DEB_FRAMES = FP_DEB_FRAMES_DEF
) (
  input  logic                                           REFRESHCLK,
  input  logic                                           RESET_N,
  input  logic [NCOLORS*WIDTH-1:0]                       LEDS,
  input  logic [NSENSE-1:0]                              SENSE,
`ifdef FP_LAMP_TEST_EN
  input  logic                                           LAMP_TEST,
`endif
  output logic [fp_ngrp(WIDTH, NCOLORS, NLED)-1:0]       ROW,
  output logic [NLED-1:0]                                PLED,
  output logic [WIDTH-1:0]                               switches,
  output logic [NSENSE*fp_ngrp(WIDTH, NCOLORS, NLED)-WIDTH-1:0] buttons,
  output logic                                           key_event,
  output logic                                           frame_tick
);

  localparam int unsigned NGRP = fp_ngrp(WIDTH, NCOLORS, NLED);
  localparam int unsigned NKEY = NSENSE * NGRP;
  localparam int unsigned SW   = $clog2(NGRP + 1);

  if ((NCOLORS * WIDTH) % NLED != 0) begin : g_bad_nled
    $error("NCOLORS*WIDTH must be a multiple of NLED");
  end
  if (NKEY <= WIDTH) begin : g_bad_nbtn
    $error("NSENSE*NGRP must exceed WIDTH so at least one button exists");
  end
  if (DEB_FRAMES < 1) begin : g_bad_deb
    $error("DEB_FRAMES must be at least 1");
  end

  logic [DWELL_W-1:0] dwell;
  logic [SW-1:0]      slot;
  logic               dwell_max;
  logic               sample_slot;
  logic               frame_end;
  logic [NGRP-1:0]    row_next;
  logic [NLED-1:0]    pled_next;
  logic [NKEY-1:0]    stable;
  logic [NKEY-1:0]    change;
  logic [WIDTH-1:0]   toggle_rise;

  always_comb begin
    dwell_max   = &dwell;
    sample_slot = dwell_max && (slot < SW'(NGRP));
    frame_end   = dwell_max && (slot == SW'(NGRP));
  end

  always_comb begin
    row_next  = '0;
    pled_next = '0;
    for (int unsigned g = 0; g < NGRP; g++) begin
      if (slot == SW'(g)) begin
        row_next[g] = 1'b1;
        pled_next   = LEDS[g*NLED +: NLED];
      end
    end
`ifdef FP_LAMP_TEST_EN
    if (LAMP_TEST && (slot < SW'(NGRP)))
      pled_next = '1;
`endif
  end

  for (genvar k = 0; k < NSENSE; k++) begin : g_sense
    for (genvar g = 0; g < NGRP; g++) begin : g_row
      localparam int unsigned IDX = fp_key_idx(k, g, NGRP);
      fp_key_debounce #(
        .DEB_FRAMES (DEB_FRAMES)
      ) u_key (
        .clk       (REFRESHCLK),
        .rst_n     (RESET_N),
        .sample    (sample_slot && (slot == SW'(g))),
        .sense     (SENSE[k]),
        .frame_end (frame_end),
        .stable    (stable[IDX]),
        .change    (change[IDX])
      );
    end
  end

  // A toggle flips only on a debounced press: changing while currently released.
  always_comb begin
    toggle_rise = change[WIDTH-1:0] & ~stable[WIDTH-1:0];
  end

  assign buttons = stable[NKEY-1:WIDTH];

  always_ff @(posedge REFRESHCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      dwell      <= '0;
      slot       <= '0;
      ROW        <= '0;
      PLED       <= '0;
      switches   <= '0;
      key_event  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      dwell      <= dwell + 1'b1;
      if (dwell_max)
        slot <= (slot == SW'(NGRP)) ? '0 : slot + 1'b1;
      ROW        <= row_next;
      PLED       <= pled_next;
      frame_tick <= frame_end;
      key_event  <= frame_end && (|change);
      if (frame_end)
        switches <= switches ^ toggle_rise;
    end
  end

endmodule

// File: tb/tb_front_panel_scanner.sv
// Directed self-checking bench for front_panel_scanner with DWELL_W=2
// (6 rows + blank slot, 28 clocks per frame).
module tb_front_panel_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [35:0] leds;
  logic [2:0]  sense;
  logic [5:0]  row;
  logic [5:0]  pled;
  logic [11:0] switches;
  logic [5:0]  buttons;
  logic        key_event;
  logic        frame_tick;
  logic [2:0]  pen;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Key 2 = SENSE[0] on row 2, key 10 = SENSE[1] on row 4, key 13 = SENSE[2] on row 1.
  assign sense = {pen[2] & row[1], pen[1] & row[4], pen[0] & row[2]};

  front_panel_scanner #(
    .WIDTH      (12),
    .NCOLORS    (3),
    .NLED       (6),
    .NSENSE     (3),
    .DWELL_W    (2),
    .DEB_FRAMES (3)
  ) dut (
    .REFRESHCLK (clk),
    .RESET_N    (rst_n),
    .LEDS       (leds),
    .SENSE      (sense),
`ifdef FP_LAMP_TEST_EN
    .LAMP_TEST  (1'b0),
`endif
    .ROW        (row),
    .PLED       (pled),
    .switches   (switches),
    .buttons    (buttons),
    .key_event  (key_event),
    .frame_tick (frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 60);
    check("frame_tick_seen", 32'(frame_tick), 32'd1);
  endtask

  task automatic wait_row(input logic [5:0] r);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (row !== r && n < 40);
    check("row_reached", 32'(row), 32'(r));
  endtask

  task automatic frames_expect(input string tag, input int nfr,
                               input logic [11:0] sw_exp, input logic [5:0] bt_exp,
                               input logic ke_last);
    for (int i = 1; i <= nfr; i++) begin
      wait_frame();
      if (i == nfr) begin
        check({tag, "_sw"}, 32'(switches), 32'(sw_exp));
        check({tag, "_bt"}, 32'(buttons), 32'(bt_exp));
        check({tag, "_ke"}, 32'(key_event), 32'(ke_last));
      end else begin
        check({tag, "_ke_early"}, 32'(key_event), 32'd0);
      end
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    leds  = {12'h000, 12'hFC0, 12'h03F};
    pen   = 3'b000;
    repeat (3) @(negedge clk);

    check("rst_row", 32'(row), 32'd0);
    check("rst_pled", 32'(pled), 32'd0);
    check("rst_sw", 32'(switches), 32'd0);
    check("rst_bt", 32'(buttons), 32'd0);
    check("rst_ke", 32'(key_event), 32'd0);
    check("rst_ft", 32'(frame_tick), 32'd0);

    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check("row_after_release", 32'(row), 32'd1);
    end while (!frame_tick && n < 40);
    check("first_tick_clk", 32'(n), 32'd28);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check("tick_one_clk", 32'(frame_tick), 32'd0);
    end while (!frame_tick && n < 40);
    check("tick_period", 32'(n), 32'd28);

    wait_row(6'b000001); check("pled_slot0", 32'(pled), 32'h3F);
    wait_row(6'b000010); check("pled_slot1", 32'(pled), 32'h00);
    wait_row(6'b000100); check("pled_slot2", 32'(pled), 32'h00);
    wait_row(6'b001000); check("pled_slot3", 32'(pled), 32'h3F);
    wait_row(6'b000000); check("pled_blank", 32'(pled), 32'h00);
    wait_frame();

    pen[0] = 1'b1;
    frames_expect("sw_press", 3, 12'h004, 6'h00, 1'b1);
    frames_expect("sw_hold", 1, 12'h004, 6'h00, 1'b0);
    pen[0] = 1'b0;
    frames_expect("sw_release", 3, 12'h004, 6'h00, 1'b1);
    pen[0] = 1'b1;
    frames_expect("sw_press2", 3, 12'h000, 6'h00, 1'b1);
    pen[0] = 1'b0;
    frames_expect("sw_release2", 3, 12'h000, 6'h00, 1'b1);

    pen[1] = 1'b1;
    frames_expect("bounce_on", 2, 12'h000, 6'h00, 1'b0);
    pen[1] = 1'b0;
    frames_expect("bounce_off", 3, 12'h000, 6'h00, 1'b0);

    pen[2] = 1'b1;
    frames_expect("btn_press", 3, 12'h000, 6'h02, 1'b1);
    pen[2] = 1'b0;
    frames_expect("btn_release", 3, 12'h000, 6'h00, 1'b1);

    pen[2] = 1'b1;
    frames_expect("pre_rst_btn", 3, 12'h000, 6'h02, 1'b1);
    pen[0] = 1'b1;
    frames_expect("pre_rst_sw", 2, 12'h000, 6'h02, 1'b0);
    wait_row(6'b001000);
    rst_n = 1'b0;
    #1;
    check("mid_rst_row", 32'(row), 32'd0);
    check("mid_rst_pled", 32'(pled), 32'd0);
    check("mid_rst_bt", 32'(buttons), 32'd0);
    check("mid_rst_sw", 32'(switches), 32'd0);
    check("mid_rst_ft", 32'(frame_tick), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    frames_expect("post_rst", 3, 12'h004, 6'h02, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
